// File: rtl/cnu_pkg.sv
// Shared constants and state type for the check-node message generator.
package cnu_pkg;

    // Default widths and degree used when the generator is instantiated bare.
    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned IDX_W_DEF  = 8;
    localparam int unsigned DC_DEF     = 8;

    // IDLE: waiting for a merge-tree result. EMIT: streaming one message per edge.
    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } cnu_state_t;

endpackage

// File: rtl/cnu_msg_gen_if.sv
// Upstream merge-tree result channel and downstream message channel.
interface cnu_msg_gen_if
    import cnu_pkg::*;
#(
    parameter int unsigned data_w = DATA_W_DEF,
    parameter int unsigned idx_w  = IDX_W_DEF,
    parameter int unsigned DC     = DC_DEF
);

    // Upstream: {min2, min1}, {idx2, idx1}, per-edge sign bits
    logic                  in_valid;
    logic                  in_ready;
    logic [2*data_w-1:0]   min_in;
    logic [2*idx_w-1:0]    idx_in;
    logic [DC-1:0]         sign_in;

    // Downstream: one {sign, magnitude} message per edge
    logic                  out_valid;
    logic                  out_ready;
    logic [data_w:0]       msg_out;
    logic [idx_w-1:0]      edge_out;
    logic                  last_out;

    // Producer of check results / consumer of messages
    modport master (
        output in_valid, min_in, idx_in, sign_in, out_ready,
        input  in_ready, out_valid, msg_out, edge_out, last_out
    );

    // The message generator itself
    modport slave (
        input  in_valid, min_in, idx_in, sign_in, out_ready,
        output in_ready, out_valid, msg_out, edge_out, last_out
    );

endinterface

// File: rtl/cnu_offset_sat.sv
// Offset-min-sum correction: subtract OFFSET from a magnitude, clamping at zero.
module cnu_offset_sat
    import cnu_pkg::*;
#(
    parameter int unsigned data_w = DATA_W_DEF,
    parameter int unsigned OFFSET = 1
) (
    input  logic [data_w-1:0] mag_i,
    output logic [data_w-1:0] mag_o
);

    // An offset at or beyond the magnitude range always clamps to zero.
    localparam bit OFF_HUGE = (longint'(OFFSET) >= (longint'(1) << data_w));
    localparam logic [data_w:0] OFF_X = OFF_HUGE ? '0 : (data_w+1)'(OFFSET);

    logic [data_w:0] diff;

    // Borrow out of the extended subtraction means the result would go negative.
    always_comb begin
        diff = {1'b0, mag_i} - OFF_X;
        if (OFF_HUGE || diff[data_w]) begin
            mag_o = '0;
        end else begin
            mag_o = diff[data_w-1:0];
        end
    end

endmodule

// File: rtl/cnu_msg_gen.sv
// Check-node message generator: expands one min-sum merge result into DC
// check-to-variable messages, one edge per cycle, with offset correction.
module cnu_msg_gen
    import cnu_pkg::*;
#(
    parameter int unsigned data_w = DATA_W_DEF,
    parameter int unsigned idx_w  = IDX_W_DEF,
    parameter int unsigned DC     = DC_DEF,
    parameter int unsigned OFFSET = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    cnu_msg_gen_if.slave  bus
);

    localparam logic [idx_w-1:0] LAST_EDGE = idx_w'(DC - 1);

    cnu_state_t        state_q, state_d;
    logic [idx_w-1:0]  cnt_q, cnt_d;

    logic [data_w-1:0] min1_q, min2_q;
    logic [idx_w-1:0]  idx1_q;
    logic [DC-1:0]     sign_q;
    logic              parity_q;

    logic              out_valid;
    logic              at_last;
    logic              fire;
    logic              capture;

    logic [DC-1:0]     sign_shift;
    logic              sign_bit;
    logic [data_w-1:0] mag_sel;
    logic [data_w-1:0] mag_off;

    // idx2 is carried by the merge tree but has no role in message generation
    logic              unused_idx2;
    assign unused_idx2 = ^bus.idx_in[2*idx_w-1:idx_w];

    assign out_valid = (state_q == EMIT);
    assign at_last   = (cnt_q == LAST_EDGE);
    assign fire      = out_valid & bus.out_ready;

    // Ready when idle, or when the final edge is leaving this cycle (zero-bubble reload)
    assign bus.in_ready = rst_n & (~out_valid | (fire & at_last));

    // State and edge counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, counter advance and capture decision
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    capture = 1'b1;
                    cnt_d   = '0;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (bus.out_ready) begin
                    if (at_last) begin
                        cnt_d = '0;
                        if (bus.in_valid) begin
                            capture = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + idx_w'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Captured check result: both minima, min1 edge, signs and their parity
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min1_q   <= '0;
            min2_q   <= '0;
            idx1_q   <= '0;
            sign_q   <= '0;
            parity_q <= 1'b0;
        end else if (capture) begin
            min1_q   <= bus.min_in[data_w-1:0];
            min2_q   <= bus.min_in[2*data_w-1:data_w];
            idx1_q   <= bus.idx_in[idx_w-1:0];
            sign_q   <= bus.sign_in;
            parity_q <= ^bus.sign_in;
        end
    end

    // Per-edge selection: the min1 edge gets min2, all others get min1
    always_comb begin
        sign_shift = sign_q >> cnt_q;
        sign_bit   = sign_shift[0];
        mag_sel    = (cnt_q == idx1_q) ? min2_q : min1_q;
    end

    cnu_offset_sat #(
        .data_w (data_w),
        .OFFSET (OFFSET)
    ) u_offset_sat (
        .mag_i (mag_sel),
        .mag_o (mag_off)
    );

    assign bus.out_valid = out_valid;
    assign bus.msg_out   = out_valid ? {parity_q ^ sign_bit, mag_off} : '0;
    assign bus.edge_out  = out_valid ? cnt_q : '0;
    assign bus.last_out  = out_valid & at_last;

endmodule

// File: tb/tb_cnu_msg_gen.sv
// Self-checking bench for cnu_msg_gen: table vectors, corner sequences and
// randomized traffic against a transaction-level reference model.
module tb_cnu_msg_gen;

    localparam int DW  = 8;
    localparam int IW  = 8;
    localparam int NDC = 8;
    localparam int OFF = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cnu_msg_gen_if #(.data_w(DW), .idx_w(IW), .DC(NDC)) bus ();

    cnu_msg_gen #(
        .data_w (DW),
        .idx_w  (IW),
        .DC     (NDC),
        .OFFSET (OFF)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [8:0] msg;
        logic [7:0] edg;
        logic       last;
    } exp_t;

    exp_t q[$];

    typedef struct {
        logic [7:0]  m1;
        logic [7:0]  m2;
        logic [7:0]  i1;
        logic [7:0]  s;
        logic [63:0] mags;   // edge e magnitude at [8*e +: 8]
        logic [7:0]  sgn;    // edge e output sign at bit e
    } vec_t;

    vec_t tbl[4];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endfunction

    // Reference: each accepted check becomes DC messages computed from min-sum rules
    function automatic void expand(input logic [7:0] m1, input logic [7:0] m2,
                                   input logic [7:0] i1, input logic [7:0] s);
        int   ones;
        int   par;
        int   mag;
        exp_t x;
        ones = 0;
        for (int e = 0; e < NDC; e++) if (s[e]) ones++;
        par = ones % 2;
        for (int e = 0; e < NDC; e++) begin
            mag = (e == int'(i1)) ? int'(m2) : int'(m1);
            mag = (mag > OFF) ? mag - OFF : 0;
            x.msg  = 9'((((par + int'(s[e])) % 2) << 8) + mag);
            x.edg  = 8'(e);
            x.last = (e == NDC - 1);
            q.push_back(x);
        end
    endfunction

    task automatic set_in(input bit v, input logic [7:0] m1, input logic [7:0] m2,
                          input logic [7:0] i1, input logic [7:0] s);
        bus.in_valid = v;
        bus.min_in   = {m2, m1};
        bus.idx_in   = {8'($urandom), i1};
        bus.sign_in  = s;
    endtask

    // One cycle: compare against the model, apply handshakes to it, advance the clock
    task automatic tick();
        bit accept;
        #1;
        chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
        chk("in_ready", 32'(bus.in_ready), 32'((q.size() == 0) || (bus.out_ready && q.size() == 1)));
        if (q.size() != 0) begin
            chk("msg_out", 32'(bus.msg_out), 32'(q[0].msg));
            chk("edge_out", 32'(bus.edge_out), 32'(q[0].edg));
            chk("last_out", 32'(bus.last_out), 32'(q[0].last));
        end
        accept = bus.in_valid && ((q.size() == 0) || (bus.out_ready && q.size() == 1));
        if (q.size() != 0 && bus.out_ready) void'(q.pop_front());
        if (accept) expand(bus.min_in[7:0], bus.min_in[15:8], bus.idx_in[7:0], bus.sign_in);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [8:0] held;

        tbl[0] = '{8'd3,  8'd7,   8'd2, 8'h05, {8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd6, 8'd2, 8'd2}, 8'h05};
        tbl[1] = '{8'd0,  8'd1,   8'd5, 8'h80, 64'd0, 8'h7F};
        tbl[2] = '{8'd10, 8'd20,  8'd9, 8'hF0, {8{8'd9}}, 8'hF0};
        tbl[3] = '{8'd1,  8'd255, 8'd7, 8'hFF, {8'd254, 56'd0}, 8'hFF};

        bus.out_ready = 1'b0;
        set_in(1'b0, 8'd0, 8'd0, 8'd0, 8'd0);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_msg_out", 32'(bus.msg_out), 32'd0);
        chk("rst_edge_out", 32'(bus.edge_out), 32'd0);
        chk("rst_last_out", 32'(bus.last_out), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", 32'(bus.in_ready), 32'd1);

        // Table vectors, out_ready held high
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, tbl[i].m1, tbl[i].m2, tbl[i].i1, tbl[i].s);
            tick();
            set_in(1'b0, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            for (int e = 0; e < NDC; e++) begin
                #1;
                chk("tbl_valid", 32'(bus.out_valid), 32'd1);
                chk("tbl_mag", 32'(bus.msg_out[7:0]), 32'(tbl[i].mags[8*e +: 8]));
                chk("tbl_sign", 32'(bus.msg_out[8]), 32'(tbl[i].sgn[e]));
                chk("tbl_edge", 32'(bus.edge_out), 32'(e));
                chk("tbl_last", 32'(bus.last_out), 32'(e == NDC - 1));
                tick();
            end
            tick();
        end

        // Back-to-back checks; in_valid held high mid-stream must not re-capture
        set_in(1'b1, 8'd5, 8'd9, 8'd3, 8'h3C);
        tick();
        set_in(1'b1, 8'd2, 8'd4, 8'd6, 8'hA5);
        for (int k = 0; k < 2 * NDC; k++) begin
            #1;
            chk("b2b_valid", 32'(bus.out_valid), 32'd1);
            chk("b2b_edge", 32'(bus.edge_out), 32'(k % NDC));
            tick();
            if (k == NDC - 1) bus.in_valid = 1'b0;
        end
        tick();

        // Stall on edge 3: outputs frozen, no skip or duplicate afterwards
        set_in(1'b1, 8'd4, 8'd6, 8'd1, 8'h12);
        tick();
        set_in(1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
        repeat (3) tick();
        #1;
        held = bus.msg_out;
        chk("stall_edge_pre", 32'(bus.edge_out), 32'd3);
        bus.out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("stall_edge", 32'(bus.edge_out), 32'd3);
            chk("stall_msg", 32'(bus.msg_out), 32'(held));
            chk("stall_valid", 32'(bus.out_valid), 32'd1);
            tick();
        end
        bus.out_ready = 1'b1;
        repeat (NDC - 3) tick();
        tick();

        // Asynchronous reset during edge 4
        set_in(1'b1, 8'd7, 8'd8, 8'd0, 8'hF0);
        tick();
        set_in(1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
        repeat (4) tick();
        #1;
        chk("pre_rst_edge", 32'(bus.edge_out), 32'd4);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("midrst_msg", 32'(bus.msg_out), 32'd0);
        chk("midrst_edge", 32'(bus.edge_out), 32'd0);
        chk("midrst_last", 32'(bus.last_out), 32'd0);
        q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("postrst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("postrst_valid", 32'(bus.out_valid), 32'd0);
        repeat (3) tick();
        set_in(1'b1, 8'd3, 8'd5, 8'd2, 8'h01);
        tick();
        set_in(1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
        #1;
        chk("postrst_first_edge", 32'(bus.edge_out), 32'd0);
        chk("postrst_first_valid", 32'(bus.out_valid), 32'd1);
        repeat (NDC + 1) tick();

        // Randomized traffic with back-pressure and boundary-heavy values
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] m1;
            logic [7:0] m2;
            m1 = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 2)) : 8'($urandom);
            m2 = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 2)) : 8'($urandom);
            set_in(($urandom_range(0, 2) != 0), m1, m2, 8'($urandom_range(0, 11)), 8'($urandom));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (NDC + 2) tick();
        chk("drain_empty", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
